// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared definitions for the video RAM arbiter: FSM state encoding, the kind
// of access currently in flight, and the default parameter values.
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

  // Default VRAM address width (2 KB) and video-streak limit.
  localparam int AW_DEF     = 11;
  localparam int STARVE_DEF = 3;

  // Width of the consecutive-video-grant counter (limit range 1..15).
  localparam int STREAK_W   = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Owner and direction of the access currently occupying the RAM slot.
  typedef enum logic [1:0] {
    ACC_VID    = 2'd0,
    ACC_CPU_RD = 2'd1,
    ACC_CPU_WR = 2'd2
  } acc_t;

endpackage

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM between the video fetch engine
// and the Z80 main CPU. Video has priority, but after STARVE consecutive video
// grants with a CPU access waiting, the CPU gets the next slot. The CPU is held
// in WAIT until its single access for the current bus cycle has completed.
//
// Ports
//   MCLK, RESET          master clock; asynchronous active-high reset
//   CPURD, CPUWE         CPU read / write strobes (held until the bus cycle ends)
//   CPUAD, CPUWD         CPU address / write data
//   CPUWAIT              high while the CPU access is still outstanding
//   VIDDV, VIDRD         CPU read data valid / registered CPU read data
//   VREQ, VAD            video fetch request (level) / fetch address
//   VACK                 one-cycle pulse: request accepted, VAD latched
//   VDV, VRD             one-cycle pulse: video data valid / registered data
//   RAD, RWE, RWD        registered RAM address / write enable / write data
//   RRD                  RAM read data, valid one edge after RAD is sampled
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          CPURD,
  input  logic          CPUWE,
  input  logic [AW-1:0] CPUAD,
  input  logic [7:0]    CPUWD,
  output logic          CPUWAIT,
  output logic          VIDDV,
  output logic [7:0]    VIDRD,
  input  logic          VREQ,
  input  logic [AW-1:0] VAD,
  output logic          VACK,
  output logic          VDV,
  output logic [7:0]    VRD,
  output logic [AW-1:0] RAD,
  output logic          RWE,
  output logic [7:0]    RWD,
  input  logic [7:0]    RRD
);

  localparam logic [STREAK_W-1:0] STARVE_L = STREAK_W'(STARVE);

  state_t              state;
  acc_t                acc;
  logic                cpu_done;
  logic [STREAK_W-1:0] streak;

  logic cpu_pend;
  logic starved;
  logic cpu_grant;
  logic vid_grant;

  // A CPU access is pending until it has been serviced once in this bus
  // cycle; cpu_done stays set while the strobe is held so the same strobe
  // never triggers a second RAM access.
  // NOTE: these are pure combinational functions of inputs and flops written
  // as continuous assigns, so there is no path that can leave one unassigned.
  assign cpu_pend  = (CPURD | CPUWE) & ~cpu_done;
  assign starved   = (streak == STARVE_L);
  assign cpu_grant = (state == IDLE) & cpu_pend & (~VREQ | starved);
  assign vid_grant = (state == IDLE) & ~cpu_grant & VREQ;

  assign CPUWAIT = cpu_pend;
  assign VIDDV   = CPURD & cpu_done;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      acc      <= ACC_VID;
      cpu_done <= 1'b0;
      streak   <= '0;
      RAD      <= '0;
      RWE      <= 1'b0;
      RWD      <= '0;
      VRD      <= '0;
      VDV      <= 1'b0;
      VIDRD    <= '0;
      VACK     <= 1'b0;
    end else begin
      // NOTE: every register here uses non-blocking assignment; the pulse
      // outputs default low first and are raised only in the state that owns
      // them, so a later assignment in the same edge overrides the default.
      VACK <= 1'b0;
      VDV  <= 1'b0;
      RWE  <= 1'b0;

      // End of the CPU bus cycle re-arms the one-access-per-strobe guard.
      if (!CPURD && !CPUWE) begin
        cpu_done <= 1'b0;
      end

      // Count video grants that overtook a waiting CPU access.
      if (!cpu_pend || cpu_grant) begin
        streak <= '0;
      end else if (vid_grant && !starved) begin
        streak <= streak + 4'd1;
      end

      case (state)
        IDLE: begin
          if (cpu_grant) begin
            RAD   <= CPUAD;
            state <= ISSUE;
            // A simultaneous read and write strobe is serviced as a write.
            if (CPUWE) begin
              RWD <= CPUWD;
              RWE <= 1'b1;
              acc <= ACC_CPU_WR;
            end else begin
              acc <= ACC_CPU_RD;
            end
          end else if (vid_grant) begin
            RAD   <= VAD;
            VACK  <= 1'b1;
            acc   <= ACC_VID;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          // Writes finish once the RAM has sampled RWE; reads wait for RRD.
          if (acc == ACC_CPU_WR) begin
            cpu_done <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (acc == ACC_VID) begin
            VRD <= RRD;
            VDV <= 1'b1;
          end else begin
            VIDRD    <= RRD;
            cpu_done <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous RAM. Expected
// read data is taken from a bench-side shadow of the RAM contents and queued
// when a request is driven; a monitor pops and compares it when VDV pulses or
// VIDDV rises. Outputs are sampled on the falling clock edge; inputs change
// 1 ns later.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW     = AW_DEF;
  localparam int STARVE = STARVE_DEF;
  localparam int DEPTH  = 1 << AW;

  logic          MCLK = 1'b0;
  logic          RESET;
  logic          CPURD, CPUWE;
  logic [AW-1:0] CPUAD;
  logic [7:0]    CPUWD;
  logic          CPUWAIT, VIDDV;
  logic [7:0]    VIDRD;
  logic          VREQ;
  logic [AW-1:0] VAD;
  logic          VACK, VDV;
  logic [7:0]    VRD;
  logic [AW-1:0] RAD;
  logic          RWE;
  logic [7:0]    RWD;
  logic [7:0]    RRD = 8'h00;

  vram_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .CPURD(CPURD), .CPUWE(CPUWE), .CPUAD(CPUAD), .CPUWD(CPUWD),
    .CPUWAIT(CPUWAIT), .VIDDV(VIDDV), .VIDRD(VIDRD),
    .VREQ(VREQ), .VAD(VAD), .VACK(VACK), .VDV(VDV), .VRD(VRD),
    .RAD(RAD), .RWE(RWE), .RWD(RWD), .RRD(RRD)
  );

  always #5 MCLK = ~MCLK;

  // ---------------- RAM model and shadow ----------------
  function automatic logic [7:0] ram_init(input logic [AW-1:0] a);
    return (a == AW'('h123)) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  logic [7:0] mem   [0:DEPTH-1];
  logic [7:0] model [0:DEPTH-1];
  bit         ram_loaded = 1'b0;

  always @(posedge MCLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ram_init(AW'(i));
      ram_loaded <= 1'b1;
    end else if (RWE) begin
      mem[RAD] <= RWD;
    end
    RRD <= mem[RAD];
  end

  // ---------------- bookkeeping ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] vid_q[$];
  logic [7:0] cpu_q[$];
  string      glog = "";
  int         vack_cnt = 0, rwe_cnt = 0, vdv_cnt = 0;
  logic       viddv_q = 1'b0;
  logic [7:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input string exp);
    checks++;
    assert (glog == exp) else begin
      errors++;
      $error("FAIL %s: observed grant order '%s' expected '%s'", tag, glog, exp);
    end
  endtask

  task automatic cyc();
    @(negedge MCLK);
    #1;
  endtask

  // Scoreboard monitor: logs grants (V video, W write cycle, C CPU read done)
  // and compares returned data against the queued expectations.
  always @(negedge MCLK) begin
    if (!RESET) begin
      if (VACK) begin
        vack_cnt++;
        glog = {glog, "V"};
      end
      if (RWE) begin
        rwe_cnt++;
        glog = {glog, "W"};
      end
      if (VDV) begin
        vdv_cnt++;
        check("vdv_expected", 32'(vid_q.size() != 0), 1);
        if (vid_q.size() != 0) begin
          mon_exp = vid_q.pop_front();
          check("sb_vrd", VRD, mon_exp);
        end
      end
      if (VIDDV && !viddv_q) begin
        glog = {glog, "C"};
        check("viddv_expected", 32'(cpu_q.size() != 0), 1);
        if (cpu_q.size() != 0) begin
          mon_exp = cpu_q.pop_front();
          check("sb_vidrd", VIDRD, mon_exp);
        end
      end
    end
    viddv_q = VIDDV;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  start_cnt;
    bit  got;
    bit  seen_c;
    int  v_after;

    RESET = 1'b1;
    CPURD = 1'b0;
    CPUWE = 1'b0;
    CPUAD = '0;
    CPUWD = '0;
    VREQ  = 1'b0;
    VAD   = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = ram_init(AW'(i));

    repeat (3) cyc();
    RESET = 1'b0;
    cyc();

    // Reset state.
    check("rst_rad", RAD, 0);
    check("rst_rwe", RWE, 0);
    check("rst_rwd", RWD, 0);
    check("rst_vrd", VRD, 0);
    check("rst_vdv", VDV, 0);
    check("rst_vidrd", VIDRD, 0);
    check("rst_viddv", VIDDV, 0);
    check("rst_vack", VACK, 0);
    check("rst_cpuwait", CPUWAIT, 0);

    // Lone video read of 0x123.
    glog = "";
    VAD  = AW'('h123);
    VREQ = 1'b1;
    vid_q.push_back(model[AW'('h123)]);
    cyc();
    check("vrd_vack", VACK, 1);
    check("vrd_rad", RAD, 'h123);
    check("vrd_vdv_early", VDV, 0);
    VREQ = 1'b0;
    VAD  = '0;
    cyc();
    check("vrd_vack_off", VACK, 0);
    check("vrd_vdv_e1", VDV, 0);
    cyc();
    check("vrd_vdv", VDV, 1);
    check("vrd_data", VRD, 8'hA5);
    cyc();
    check("vrd_vdv_off", VDV, 0);
    check_log("vrd_order", "V");

    // Lone CPU write of 0x3C to 0x040, strobe held afterwards.
    start_cnt = rwe_cnt;
    CPUAD = AW'('h040);
    CPUWD = 8'h3C;
    CPUWE = 1'b1;
    model[AW'('h040)] = 8'h3C;
    cyc();
    check("wr_rwe", RWE, 1);
    check("wr_rad", RAD, 'h040);
    check("wr_rwd", RWD, 8'h3C);
    check("wr_wait_busy", CPUWAIT, 1);
    cyc();
    check("wr_rwe_off", RWE, 0);
    check("wr_wait_done", CPUWAIT, 0);
    repeat (3) begin
      cyc();
      check("wr_hold_wait", CPUWAIT, 0);
    end
    check("wr_rwe_cycles", rwe_cnt - start_cnt, 1);
    check("wr_ram", mem[AW'('h040)], 8'h3C);
    CPUWE = 1'b0;
    cyc();
    cyc();

    // CPU read back of 0x040, strobe held for 10 cycles after completion.
    CPUAD = AW'('h040);
    CPURD = 1'b1;
    cpu_q.push_back(model[AW'('h040)]);
    cyc();
    check("rd_wait_e1", CPUWAIT, 1);
    check("rd_viddv_e1", VIDDV, 0);
    cyc();
    check("rd_wait_e2", CPUWAIT, 1);
    check("rd_viddv_e2", VIDDV, 0);
    cyc();
    check("rd_wait_done", CPUWAIT, 0);
    check("rd_viddv", VIDDV, 1);
    check("rd_vidrd", VIDRD, 8'h3C);
    repeat (10) begin
      cyc();
      check("rd_hold_wait", CPUWAIT, 0);
      check("rd_hold_viddv", VIDDV, 1);
    end
    CPURD = 1'b0;
    cyc();
    check("rd_drop_viddv", VIDDV, 0);
    check("rd_drop_wait", CPUWAIT, 0);

    // Reassert: a new access must be issued.
    CPUAD = AW'('h124);
    CPURD = 1'b1;
    cpu_q.push_back(model[AW'('h124)]);
    cyc();
    check("rd2_wait", CPUWAIT, 1);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      if (VIDDV) got = 1'b1;
    end
    check("rd2_done", got, 1);
    check("rd2_vidrd", VIDRD, model[AW'('h124)]);
    CPURD = 1'b0;
    cyc();

    // Starvation guard: VREQ held, CPU read pending.
    glog   = "";
    VAD    = AW'('h200);
    VREQ   = 1'b1;
    CPUAD  = AW'('h041);
    CPURD  = 1'b1;
    cpu_q.push_back(model[AW'('h041)]);
    seen_c  = 1'b0;
    v_after = 0;
    for (int i = 0; i < 40 && v_after == 0; i++) begin
      cyc();
      if (VACK) begin
        vid_q.push_back(model[VAD]);
        VAD = VAD + AW'(1);
        if (seen_c) v_after++;
      end
      if (VIDDV && !seen_c) begin
        seen_c = 1'b1;
        CPURD  = 1'b0;
      end
    end
    VREQ  = 1'b0;
    CPURD = 1'b0;
    repeat (4) cyc();
    check("starve_cpu_seen", seen_c, 1);
    check_log("starve_order", "VVVCV");

    // Simultaneous video request and CPU write with no streak built up.
    glog  = "";
    VAD   = AW'('h300);
    VREQ  = 1'b1;
    CPUAD = AW'('h050);
    CPUWD = 8'h77;
    CPUWE = 1'b1;
    model[AW'('h050)] = 8'h77;
    vid_q.push_back(model[AW'('h300)]);
    cyc();
    check("sim_vack", VACK, 1);
    check("sim_wait_e1", CPUWAIT, 1);
    VREQ = 1'b0;
    cyc();
    cyc();
    check("sim_vdv", VDV, 1);
    check("sim_wait_e3", CPUWAIT, 1);
    cyc();
    check("sim_rwe", RWE, 1);
    check("sim_rad", RAD, 'h050);
    cyc();
    check("sim_wait_done", CPUWAIT, 0);
    CPUWE = 1'b0;
    cyc();
    check_log("sim_order", "VW");
    check("sim_ram", mem[AW'('h050)], 8'h77);

    // Reset during ISSUE of a video read: no VDV for it.
    start_cnt = vdv_cnt;
    VAD  = AW'('h123);
    VREQ = 1'b1;
    cyc();
    check("rstm_vack", VACK, 1);
    RESET = 1'b1;
    VREQ  = 1'b0;
    #1;
    check("rstm_vack_clr", VACK, 0);
    check("rstm_rad_clr", RAD, 0);
    repeat (2) cyc();
    RESET = 1'b0;
    repeat (5) cyc();
    check("rstm_no_vdv", vdv_cnt - start_cnt, 0);
    check("rstm_wait", CPUWAIT, 0);

    check("vid_q_empty", vid_q.size(), 0);
    check("cpu_q_empty", cpu_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
